// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 unsigned multiply controller: time-shares one external 4x4
// multiplier over four cycles and accumulates the shifted nibble products.
module mul8_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p,
  output logic        busy,
  output logic        done,
  output logic [15:0] p
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  step;
  logic [7:0]  ra, rb;
  logic [15:0] acc;
  logic [15:0] pp_shifted;
  logic        accept;

  // Partial-product alignment: the step index encodes the nibble weights.
  function automatic logic [15:0] align_pp(input logic [7:0] pp, input logic [1:0] s);
    case (s)
      2'd0:    align_pp = {8'h00, pp};
      2'd3:    align_pp = {pp, 8'h00};
      default: align_pp = {4'h0, pp, 4'h0};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    mul_a     = 4'h0;
    mul_b     = 4'h0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = MUL;
        end
      end
      MUL: begin
        busy  = 1'b1;
        // step[0] picks the high nibble of ra, step[1] the high nibble of rb
        mul_a = step[0] ? ra[7:4] : ra[3:0];
        mul_b = step[1] ? rb[7:4] : rb[3:0];
        if (step == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = MUL;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pp_shifted = align_pp(mul_p, step);

  always_ff @(posedge clk) begin
    if (rst) begin
      step <= 2'd0;
      ra   <= 8'h00;
      rb   <= 8'h00;
      acc  <= 16'h0000;
      p    <= 16'h0000;
    end else if (accept) begin
      step <= 2'd0;
      ra   <= a;
      rb   <= b;
      acc  <= 16'h0000;
    end else if (state == MUL) begin
      step <= step + 2'd1;
      acc  <= acc + pp_shifted;
      if (step == 2'd3) p <= acc + pp_shifted;
    end
  end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Directed and random checks of mul8_seq_ctrl with a behavioural 4x4 multiplier
// closing the mul_a/mul_b/mul_p loop.
module tb_mul8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a, b;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_p;
  logic        busy, done;
  logic [15:0] p;

  int n_chk  = 0;
  int n_fail = 0;

  mul8_seq_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_p (mul_p),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  assign mul_p = {4'h0, mul_a} * {4'h0, mul_b};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp,
                       input logic [15:0] p_prev, input string tag);
    int n;
    a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_p_hold"}, p, p_prev);
    n = 1;
    while (!done && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_lat"}, n, 5);
    chk({tag, "_p"}, p, exp);
    tick();
    chk({tag, "_done_once"}, done, 1'b0);
    chk({tag, "_p_held"}, p, exp);
  endtask

  initial begin
    logic [7:0]  ea [4];
    logic [7:0]  eb [4];
    logic [15:0] last_p;

    ea = '{4'h2, 4'h1, 4'h2, 4'h1};
    eb = '{4'h4, 4'h4, 4'h3, 4'h3};

    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_p", p, 16'h0000);
      chk("rst_mul", {mul_a, mul_b}, 8'h00);
    end

    // Walk through 0x12 * 0x34 cycle by cycle
    a = 8'h12; b = 8'h34; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk("seq_busy", busy, 1'b1);
      chk("seq_done", done, 1'b0);
      chk("seq_mul_a", mul_a, ea[i]);
      chk("seq_mul_b", mul_b, eb[i]);
      chk("seq_p_hold", p, 16'h0000);
    end
    tick();
    chk("seq_done_pulse", done, 1'b1);
    chk("seq_busy_off", busy, 1'b0);
    chk("seq_p", p, 16'h03A8);
    chk("seq_mul_idle", {mul_a, mul_b}, 8'h00);
    tick();
    chk("seq_done_end", done, 1'b0);
    chk("seq_p_held", p, 16'h03A8);

    do_op(8'hFF, 8'hFF, 16'hFE01, 16'h03A8, "ff_ff");
    do_op(8'h00, 8'hA7, 16'h0000, 16'hFE01, "zero");
    do_op(8'hA5, 8'h3C, 16'h26AC, 16'h0000, "a5_3c");

    // Start held high: one result every 5 cycles, operands toggled mid-run
    a = 8'h0F; b = 8'h10; start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      chk("b2b_done", done, (c % 5) == 0);
      chk("b2b_busy", busy, (c % 5) != 0);
      if ((c % 5) == 0) chk("b2b_p", p, 16'h00F0);
      if ((c % 5) >= 1 && (c % 5) <= 3) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end else begin
        a = 8'h0F; b = 8'h10;
      end
    end
    start = 1'b0;
    tick();
    chk("b2b_idle", busy, 1'b0);

    // Reset during step2
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("mid_step2", {mul_a, mul_b}, 8'hFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_busy", busy, 1'b0);
    chk("mid_p", p, 16'h0000);
    chk("mid_done", done, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_no_done", done, 1'b0);
    end
    do_op(8'h03, 8'h05, 16'h000F, 16'h0000, "after_rst");

    // Random operands with random idle gaps
    last_p = 16'h000F;
    for (int k = 0; k < 1000; k++) begin
      logic [7:0]  x, y;
      logic [15:0] e;
      int gap;
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      e = {8'h00, x} * {8'h00, y};
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("rnd_gap_done", done, 1'b0);
      end
      do_op(x, y, e, last_p, "rnd");
      last_p = e;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
